// File: rtl/snax_wide_mem_reader.sv
// Wide read initiator: splits each wide beat into one narrow read per bank and
// reassembles the fixed 1-cycle-latency responses into a 2-deep wide output FIFO.
package snax_wide_mem_reader_pkg;
  localparam int unsigned MemAddrWidth = 48;
  localparam int unsigned MemDataWidth = 32;
  localparam int unsigned CoreIdWidth  = 8;
  localparam int unsigned AmoWidth     = 4;

  typedef struct packed {
    logic [CoreIdWidth-1:0] core_id;
    logic                   is_core;
  } mem_user_t;

  typedef struct packed {
    logic [MemAddrWidth-1:0]   addr;
    logic                      write;
    logic [MemDataWidth-1:0]   data;
    logic [MemDataWidth/8-1:0] strb;
    logic [AmoWidth-1:0]       amo;
    mem_user_t                 user;
  } mem_req_chan_t;

  typedef struct packed {
    logic          q_valid;
    mem_req_chan_t q;
  } mem_req_t;

  typedef struct packed {
    logic [MemDataWidth-1:0] data;
  } mem_rsp_chan_t;

  typedef struct packed {
    logic          q_ready;
    mem_rsp_chan_t p;
  } mem_rsp_t;
endpackage

module snax_wide_mem_reader
  import snax_wide_mem_reader_pkg::*;
#(
  parameter int unsigned AddrWidth       = MemAddrWidth,
  parameter int unsigned NarrowDataWidth = MemDataWidth,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned NumBanks        = WideDataWidth / NarrowDataWidth,
  parameter int unsigned LenWidth        = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [AddrWidth-1:0]           cmd_base_i,
  input  logic [LenWidth-1:0]            cmd_beats_i,
  output mem_req_t [NumBanks-1:0]        mem_req_o,
  input  mem_rsp_t [NumBanks-1:0]        mem_rsp_i,
  output logic                           dma_access_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [WideDataWidth-1:0]       out_data_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned BeatBytes = WideDataWidth / 8;
  localparam int unsigned LaneBytes = NarrowDataWidth / 8;
  localparam int unsigned OffBits   = $clog2(BeatBytes);
  localparam logic [0:0]  StIdle    = 1'b0;
  localparam logic [0:0]  StRun     = 1'b1;
  localparam logic [AddrWidth-1:0] BaseMask = {{(AddrWidth-OffBits){1'b1}}, {OffBits{1'b0}}};

  logic [0:0]                                state_q, state_d;
  logic [AddrWidth-1:0]                      base_q, base_d;
  logic [LenWidth-1:0]                       beats_q, beats_d, idx_q, idx_d;
  logic [NumBanks-1:0]                       pend_q, pend_d, lane_done_q, lane_done_d;
  logic [NumBanks-1:0][NarrowDataWidth-1:0]  lane_data_q, lane_data_d;
  logic [1:0][WideDataWidth-1:0]             fifo_q, fifo_d;
  logic                                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]                                count_q, count_d;
  logic                                      done_q, done_d;

  logic [NumBanks-1:0]      q_valid_s, hs_s;
  logic [AddrWidth-1:0]     beat_addr_s;
  logic [WideDataWidth-1:0] beat_s;
  logic                     cmd_hs_s, complete_s, push_s, pop_s, last_s;

  assign cmd_hs_s    = (state_q == StIdle) && cmd_valid_i;
  assign beat_addr_s = base_q + (AddrWidth'(idx_q) << OffBits);
  // The FIFO-space qualifier uses the registered count so out_ready_i never reaches the banks.
  assign complete_s  = (state_q == StRun) && (&(pend_q | lane_done_q)) && (count_q < 2'd2);
  assign last_s      = (idx_q + LenWidth'(1)) == beats_q;
  assign push_s      = complete_s;
  assign pop_s       = (count_q != 2'd0) && out_ready_i;

  // Per-lane issue enables and the beat image from captured or just-arriving data
  always_comb begin
    q_valid_s = '0;
    hs_s      = '0;
    beat_s    = '0;
    for (int i = 0; i < NumBanks; i++) begin
      q_valid_s[i] = (state_q == StRun) && (idx_q < beats_q) && !pend_q[i] && !lane_done_q[i];
      hs_s[i]      = q_valid_s[i] && mem_rsp_i[i].q_ready;
      beat_s[i*NarrowDataWidth +: NarrowDataWidth] =
        pend_q[i] ? mem_rsp_i[i].p.data : lane_data_q[i];
    end
  end

  // Bank request fields; everything but addr/strb is a constant read encoding
  always_comb begin
    mem_req_o = '0;
    for (int i = 0; i < NumBanks; i++) begin
      mem_req_o[i].q_valid = q_valid_s[i];
      if (q_valid_s[i]) begin
        mem_req_o[i].q.addr = beat_addr_s + AddrWidth'(i * LaneBytes);
        mem_req_o[i].q.strb = '1;
      end else begin
        mem_req_o[i].q.addr = '0;
        mem_req_o[i].q.strb = '0;
      end
    end
  end

  // Command acceptance, beat sequencing and lane capture
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    beats_d     = beats_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    lane_done_d = lane_done_q;
    lane_data_d = lane_data_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_hs_s) begin
          base_d      = cmd_base_i & BaseMask;
          beats_d     = cmd_beats_i;
          idx_d       = '0;
          pend_d      = '0;
          lane_done_d = '0;
          if (cmd_beats_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (complete_s) begin
          pend_d      = '0;
          lane_done_d = '0;
          idx_d       = idx_q + LenWidth'(1);
          if (last_s) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          // Responses land exactly one cycle after the handshake, so pend is a 1-cycle flag.
          for (int i = 0; i < NumBanks; i++) begin
            pend_d[i] = hs_s[i];
            if (pend_q[i]) begin
              lane_data_d[i] = mem_rsp_i[i].p.data;
              lane_done_d[i] = 1'b1;
            end else begin
              lane_done_d[i] = lane_done_q[i];
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Two-entry output FIFO bookkeeping
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = beat_s;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      beats_q     <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      lane_done_q <= '0;
      lane_data_q <= '0;
      fifo_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      beats_q     <= beats_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      lane_done_q <= lane_done_d;
      lane_data_q <= lane_data_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
  assign dma_access_o = (state_q == StRun);
  assign done_o       = done_q;
  assign out_valid_o  = (count_q != 2'd0);
  assign out_data_o   = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_snax_wide_mem_reader.sv
// Self-checking bench: banks echo their request address as read data, and the
// expected beats are rebuilt from base/beat arithmetic.
module tb_snax_wide_mem_reader;
  import snax_wide_mem_reader_pkg::*;

  localparam int NB = 16;
  localparam int WW = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, dma, out_valid, out_ready, busy, done;
  logic [47:0] cmd_base;
  logic [15:0] cmd_beats;
  logic [WW-1:0] out_data;
  mem_req_t [NB-1:0] mem_req;
  mem_rsp_t [NB-1:0] mem_rsp;
  logic [NB-1:0] rdy;
  logic [31:0] rsp_data [NB];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  snax_wide_mem_reader dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_beats_i(cmd_beats), .mem_req_o(mem_req), .mem_rsp_i(mem_rsp),
    .dma_access_o(dma), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      mem_rsp[i].q_ready = rdy[i];
      mem_rsp[i].p.data  = rsp_data[i];
    end
  end

  // Bank model: data is the handshaken address one cycle later, noise otherwise
  logic [NB-1:0] hs_r;
  logic [47:0]   a_r [NB];
  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) begin
      hs_r[i] <= mem_req[i].q_valid & rdy[i];
      a_r[i]  <= mem_req[i].q.addr;
    end
  end
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) rsp_data[i] <= hs_r[i] ? a_r[i][31:0] : $urandom;
  end

  function automatic int count_bad(input mem_req_t [NB-1:0] r);
    int n = 0;
    for (int i = 0; i < NB; i++)
      if (r[i].q_valid && (r[i].q.write !== 1'b0 || r[i].q.data !== '0 || r[i].q.strb !== 4'hF ||
                           r[i].q.amo !== '0 || r[i].q.user !== '0)) n++;
    return n;
  endfunction

  function automatic logic [NB-1:0] qv(input mem_req_t [NB-1:0] r);
    logic [NB-1:0] v = '0;
    for (int i = 0; i < NB; i++) v[i] = r[i].q_valid;
    return v;
  endfunction

  function automatic logic [47:0] exp_addr(input logic [47:0] b, input int k, input int i);
    logic [47:0] ab = b & ~48'h3F;
    return ab + 48'(k) * 48'd64 + 48'(i * 4);
  endfunction

  function automatic logic [WW-1:0] exp_beat(input logic [47:0] b, input int k);
    logic [WW-1:0] r = '0;
    logic [47:0] a;
    for (int i = 0; i < NB; i++) begin
      a = exp_addr(b, k, i);
      r[i*32 +: 32] = a[31:0];
    end
    return r;
  endfunction

  // Monitor: bank handshakes, output handshakes, done pulses
  int iss_cnt [NB] = '{default: 0};
  logic [47:0] iss_addr [NB][256];
  int bad_fields = 0, qv_cycles = 0, done_cnt = 0, done_cyc = 0;
  logic [WW-1:0] got_data [$];
  int got_cyc [$];
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_req[i].q_valid && rdy[i]) begin
          iss_addr[i][iss_cnt[i] % 256] <= mem_req[i].q.addr;
          iss_cnt[i] <= iss_cnt[i] + 1;
        end
      end
      bad_fields <= bad_fields + count_bad(mem_req);
      if (qv(mem_req) != '0) qv_cycles <= qv_cycles + 1;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  task automatic send_cmd(input logic [47:0] b, input logic [15:0] n, output int c0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = b; cmd_beats = n; c0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_base = {16'($urandom), 32'($urandom)}; cmd_beats = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget, input bit rnd, output bit ok);
    int n = 0;
    while ((busy || out_valid) && n < budget) begin
      @(posedge clk); #1; n++;
      if (rnd) begin
        rdy = 16'(~($urandom & $urandom));
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    ok = !(busy || out_valid);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_beats = '0; rdy = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({busy, dma, out_valid, done} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, dma, out_valid, done}); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (mem_req !== '0) begin failures++; $display("FAIL reset_mem_req got=%h exp=0", mem_req); end
  endtask

  task automatic test_basic();
    int s, d0, bf0, c0; int ic0 [NB]; bit ok;
    rdy = '1; out_ready = 1'b1;
    s = got_data.size(); d0 = done_cnt; bf0 = bad_fields; ic0 = iss_cnt;
    send_cmd(48'h1000, 16'd2, c0);
    wait_idle(60, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout busy=%b out_valid=%b exp idle", busy, out_valid); end
    checks++; if (got_data.size() - s !== 2) begin failures++; $display("FAIL basic_beats got=%0d exp=2", got_data.size() - s); end
    if (got_data.size() - s >= 2) begin
      for (int k = 0; k < 2; k++) begin
        checks++; if (got_data[s+k] !== exp_beat(48'h1000, k)) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", k, got_data[s+k], exp_beat(48'h1000, k)); end
      end
      checks++; if (got_cyc[s] - c0 !== 3) begin failures++; $display("FAIL basic_out_cyc0 got=%0d exp=3", got_cyc[s] - c0); end
      checks++; if (got_cyc[s+1] - c0 !== 5) begin failures++; $display("FAIL basic_out_cyc1 got=%0d exp=5", got_cyc[s+1] - c0); end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt - d0); end
    checks++; if (done_cyc - c0 !== 5) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=5", done_cyc - c0); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (iss_cnt[i] - ic0[i] !== 2 || iss_addr[i][ic0[i] % 256] !== exp_addr(48'h1000, 0, i) ||
          iss_addr[i][(ic0[i] + 1) % 256] !== exp_addr(48'h1000, 1, i)) begin
        failures++; $display("FAIL basic_lane%0d_issue cnt=%0d a0=%h a1=%h exp cnt=2 a0=%h a1=%h", i, iss_cnt[i] - ic0[i],
          iss_addr[i][ic0[i] % 256], iss_addr[i][(ic0[i] + 1) % 256], exp_addr(48'h1000, 0, i), exp_addr(48'h1000, 1, i));
      end
    end
    checks++; if (bad_fields - bf0 !== 0) begin failures++; $display("FAIL basic_req_fields got=%0d bad exp=0", bad_fields - bf0); end
  endtask

  task automatic test_stall();
    int s, d0, c0; int ic0 [NB]; bit ok;
    rdy = '1; rdy[5] = 1'b0; out_ready = 1'b1;
    s = got_data.size(); d0 = done_cnt; ic0 = iss_cnt;
    send_cmd(48'h1000, 16'd2, c0);
    repeat (4) @(posedge clk);
    #1; rdy[5] = 1'b1;
    wait_idle(60, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout busy=%b exp idle", busy); end
    checks++; if (got_data.size() - s !== 2) begin failures++; $display("FAIL stall_beats got=%0d exp=2", got_data.size() - s); end
    if (got_data.size() - s >= 2) begin
      for (int k = 0; k < 2; k++) begin
        checks++; if (got_data[s+k] !== exp_beat(48'h1000, k)) begin failures++; $display("FAIL stall_data%0d got=%h exp=%h", k, got_data[s+k], exp_beat(48'h1000, k)); end
      end
      checks++; if (got_cyc[s] - c0 !== 7) begin failures++; $display("FAIL stall_out_cyc0 got=%0d exp=7", got_cyc[s] - c0); end
    end
    checks++; if (done_cyc - c0 !== 9 || done_cnt - d0 !== 1) begin failures++; $display("FAIL stall_done cyc=%0d cnt=%0d exp cyc=9 cnt=1", done_cyc - c0, done_cnt - d0); end
    for (int i = 0; i < NB; i++) begin
      checks++; if (iss_cnt[i] - ic0[i] !== 2) begin failures++; $display("FAIL stall_lane%0d_issues got=%0d exp=2", i, iss_cnt[i] - ic0[i]); end
    end
  endtask

  task automatic test_backpressure();
    int s, d0, c0, bad; int ic0 [NB]; bit ok;
    logic [47:0] b = {16'($urandom), 32'($urandom)};
    rdy = '1; out_ready = 1'b0;
    s = got_data.size(); d0 = done_cnt; ic0 = iss_cnt;
    send_cmd(b, 16'd4, c0);
    cmd_valid = 1'b1; cmd_base = ~b; cmd_beats = 16'd7;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if ({out_valid, busy, dma} !== 3'b111) begin failures++; $display("FAIL bp_flags got=%b exp=111", {out_valid, busy, dma}); end
    checks++; if (out_data !== exp_beat(b, 0)) begin failures++; $display("FAIL bp_head got=%h exp=%h", out_data, exp_beat(b, 0)); end
    checks++; if (qv(mem_req) !== '0) begin failures++; $display("FAIL bp_no_beat3 q_valid=%h exp=0", qv(mem_req)); end
    bad = 0;
    for (int i = 0; i < NB; i++) if (iss_cnt[i] - ic0[i] !== 3) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_issues_held lanes_off=%0d exp=0 (3 beats each)", bad); end
    cmd_valid = 1'b0; out_ready = 1'b1;
    wait_idle(80, 1'b0, ok);
    checks++; if (!ok || got_data.size() - s !== 4) begin failures++; $display("FAIL bp_drain beats=%0d exp=4", got_data.size() - s); end
    for (int k = 0; k < 4 && k < got_data.size() - s; k++) begin
      checks++; if (got_data[s+k] !== exp_beat(b, k)) begin failures++; $display("FAIL bp_data%0d got=%h exp=%h", k, got_data[s+k], exp_beat(b, k)); end
    end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_zero();
    int d0, q0, c0;
    rdy = '1; out_ready = 1'b1;
    d0 = done_cnt; q0 = qv_cycles;
    send_cmd({16'($urandom), 32'($urandom)}, 16'd0, c0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1 || done_cyc - c0 !== 1) begin failures++; $display("FAIL zero_done cnt=%0d cyc=%0d exp cnt=1 cyc=1", done_cnt - d0, done_cyc - c0); end
    checks++; if (qv_cycles - q0 !== 0) begin failures++; $display("FAIL zero_no_req got=%0d cycles exp=0", qv_cycles - q0); end
    checks++; if ({cmd_ready, busy, out_valid} !== 3'b100) begin failures++; $display("FAIL zero_idle got=%b exp=100", {cmd_ready, busy, out_valid}); end
  endtask

  task automatic test_wrap();
    int s, c0; int ic0 [NB]; bit ok;
    logic [47:0] b = 48'hFFFF_FFFF_FFC0;
    rdy = '1; out_ready = 1'b1;
    s = got_data.size(); ic0 = iss_cnt;
    send_cmd(b, 16'd2, c0);
    wait_idle(60, 1'b0, ok);
    checks++; if (iss_addr[0][(ic0[0] + 1) % 256] !== 48'h0) begin failures++; $display("FAIL wrap_lane0_beat1 got=%h exp=0", iss_addr[0][(ic0[0] + 1) % 256]); end
    checks++; if (iss_addr[15][ic0[15] % 256] !== 48'hFFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_lane15_beat0 got=%h exp=fffffffffffc", iss_addr[15][ic0[15] % 256]); end
    checks++; if (!ok || got_data.size() - s !== 2) begin failures++; $display("FAIL wrap_beats got=%0d exp=2", got_data.size() - s); end
    for (int k = 0; k < 2 && k < got_data.size() - s; k++) begin
      checks++; if (got_data[s+k] !== exp_beat(b, k)) begin failures++; $display("FAIL wrap_data%0d got=%h exp=%h", k, got_data[s+k], exp_beat(b, k)); end
    end
  endtask

  task automatic test_reset_mid();
    int s, d0, c0; bit ok;
    logic [47:0] b = {16'($urandom), 32'($urandom)};
    rdy = '1; out_ready = 1'b1;
    send_cmd(48'h2000, 16'd2, c0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if ({cmd_ready, busy, dma, out_valid, done} !== 5'b10000) begin failures++; $display("FAIL rstmid_flags got=%b exp=10000", {cmd_ready, busy, dma, out_valid, done}); end
    checks++; if (out_data !== '0 || mem_req !== '0) begin failures++; $display("FAIL rstmid_outputs out_data=%h mem_req=%h exp 0", out_data, mem_req); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, out_valid} !== 2'b00) begin failures++; $display("FAIL rstmid_discard got=%b exp=00", {busy, out_valid}); end
    s = got_data.size(); d0 = done_cnt;
    send_cmd(b, 16'd3, c0);
    wait_idle(60, 1'b0, ok);
    checks++; if (!ok || got_data.size() - s !== 3 || done_cnt - d0 !== 1) begin failures++; $display("FAIL rstmid_after beats=%0d done=%0d exp 3/1", got_data.size() - s, done_cnt - d0); end
    for (int k = 0; k < 3 && k < got_data.size() - s; k++) begin
      checks++; if (got_data[s+k] !== exp_beat(b, k)) begin failures++; $display("FAIL rstmid_data%0d got=%h exp=%h", k, got_data[s+k], exp_beat(b, k)); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int s, d0, bf0, c0, n, bad; int ic0 [NB]; bit ok;
      logic [47:0] b = {16'($urandom), 32'($urandom)};
      n = $urandom_range(1, 5);
      s = got_data.size(); d0 = done_cnt; bf0 = bad_fields; ic0 = iss_cnt;
      send_cmd(b, 16'(n), c0);
      wait_idle(400, 1'b1, ok);
      out_ready = 1'b1;
      checks++; if (!ok || got_data.size() - s !== n) begin failures++; $display("FAIL rand%0d_beats got=%0d exp=%0d", it, got_data.size() - s, n); end
      for (int k = 0; k < n && k < got_data.size() - s; k++) begin
        checks++; if (got_data[s+k] !== exp_beat(b, k)) begin failures++; $display("FAIL rand%0d_data%0d got=%h exp=%h", it, k, got_data[s+k], exp_beat(b, k)); end
      end
      bad = 0;
      for (int i = 0; i < NB; i++) begin
        if (iss_cnt[i] - ic0[i] !== n) bad++;
        for (int k = 0; k < n; k++) if (iss_addr[i][(ic0[i] + k) % 256] !== exp_addr(b, k, i)) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rand%0d_issues errors=%0d exp=0", it, bad); end
      checks++; if (done_cnt - d0 !== 1 || bad_fields - bf0 !== 0) begin failures++; $display("FAIL rand%0d_done_fields done=%0d bad=%0d exp 1/0", it, done_cnt - d0, bad_fields - bf0); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_zero();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, exp completion");
    $fatal(1);
  end
endmodule

// File: doc/snax_wide_mem_reader.md
# snax_wide_mem_reader

Bank-parallel read initiator for the SNAX multi-bank local memory. It accepts a wide read command (base address, beat count) and splits each wide beat into NumBanks narrow requests, one per bank, on the banks' `mem_req_t`/`mem_rsp_t` valid-ready port. It collects the fixed 1-cycle-latency read data and reassembles it into WideDataWidth beats, which it delivers on a valid/ready stream. It sits between an accelerator streamer or DMA front-end and the bank array, and is the requesting end of the bank memory protocol.

## Interface
- AddrWidth, 48, byte address width of bank requests and command base
- NarrowDataWidth, 32, per-bank data width
- WideDataWidth, 512, output beat width
- NumBanks, WideDataWidth/NarrowDataWidth, banks driven in parallel (16)
- LenWidth, 16, width of beat count
- mem_req_t, logic, bank request struct (q_valid, q.addr, q.write, q.data, q.strb, q.amo, q.user.core_id, q.user.is_core)
- mem_rsp_t, logic, bank response struct (q_ready, p.data)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when both high
- cmd_base_i  in  AddrWidth  byte base; low log2(WideDataWidth/8) bits forced to 0
- cmd_beats_i  in  LenWidth  number of wide beats
- mem_req_o  out  NumBanks x mem_req_t  per-bank requests
- mem_rsp_i  in  NumBanks x mem_rsp_t  per-bank responses
- dma_access_o  out  1  high while FSM in RUN
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  output beat accept
- out_data_o  out  WideDataWidth  beat; bank i in bits [i*NarrowDataWidth +: NarrowDataWidth]
- busy_o  out  1  FSM not IDLE
- done_o  out  1  one-cycle pulse, command finished

## Operation
- FSM IDLE/RUN. IDLE: cmd_ready_o=1. On handshake, latch base and beats, clear beat index, go RUN. beats=0: stay IDLE, pulse done_o next cycle, no requests issued.
- Per-lane state: pend[i] (request accepted last cycle), done[i] (data captured in lane register).
- In RUN with beat index < beats: q_valid[i] = ~pend[i] & ~done[i]. Lanes handshake independently.
- Request fields: q.addr = base + idx*(WideDataWidth/8) + i*(NarrowDataWidth/8), computed modulo 2^AddrWidth (wrap). q.write=0, q.data=0, q.strb=all ones, q.amo=0, q.user.core_id=0, q.user.is_core=0.
- pend[i] is set on handshake and cleared next cycle, because response data is valid exactly one cycle after the handshake (no p_valid).
- complete = AND over i of (done[i] | pend[i]), qualified by FIFO count < 2 (registered count; no combinational path from out_ready_i to requests).
- If complete: push {lane registers for done lanes, mem_rsp_i[i].p.data for pend lanes} into the 2-entry output FIFO, clear all pend/done, increment idx. Otherwise each pend lane captures p.data into its lane register and sets done.
- Last push: go IDLE, done_o=1 the following cycle. The FIFO may still hold beats; they drain normally.
- FIFO: out_valid_o = count!=0, out_data_o = head. Pop on out_valid_o & out_ready_i. Simultaneous push and pop keeps count unchanged. Order is preserved.
- cmd_valid_i while RUN is ignored (cmd_ready_o=0).

## Timing
- Reset values: cmd_ready_o=1; all q_valid=0, other request fields 0; dma_access_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0. FIFO, pend, done, and counters are cleared.
- Cycle 0 command handshake; cycle 1 q_valid on all lanes; if all q_ready are high, data arrives cycle 2, push at end of cycle 2, out_valid_o in cycle 3.
- Steady state with all ready: one beat per 2 cycles. For N beats, last push at end of cycle 2N; done_o and IDLE in cycle 2N+1.
- A stalled lane (q_ready=0) delays only the beat completion; completed lanes hold their data.
- FIFO full (count=2): responses are captured into lane registers; push waits until count<2.
- Reset mid-RUN: immediate return to reset values; in-flight responses are discarded.

## Test plan
- Reset with no stimulus -> cmd_ready_o=1, every other output 0, out_data_o=0.
- base 0x1000, beats 2, all q_ready=1, out_ready=1, bank i returns addr -> beat0 addrs 0x1000..0x103C step 4, beat1 0x1040..0x107C; out_valid_o cycles 3 and 5; lane i data correct; done_o in cycle 5.
- Same command, bank 5 q_ready=0 for 4 cycles -> other lanes issue once only; beat0 pushed one cycle after bank 5 response; data intact.
- beats 4, out_ready_i=0 -> FIFO holds beats 0,1; beat 2 lanes captured and done; no beat 3 requests. Release out_ready -> beats 0..3 emitted in order; done_o once.
- beats 0 -> done_o in cycle 1, no q_valid ever high.
- base 0xFFFF_FFFF_FFC0 (48-bit), beats 2 -> beat1 lane 0 address 0x0 (wrap). Assert reset at cycle 2 -> outputs reset values; next command completes normally.
